// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//
// Converts one 8-bit or 16-bit read/write request into one or two byte
// accesses on a simple byte-wide memory port. Each byte phase (LO, then HI
// for wide accesses) lasts BYTE_WAIT+1 cycles. A one-cycle rsp_valid pulse
// signals completion. Only one transaction is in flight at a time.
//
// Parameters
//   BYTE_WAIT   extra wait cycles per byte phase (0..15)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   requester has a transaction
//   req_ready   controller can accept (high only in IDLE)
//   req_write   1 = write, 0 = read
//   req_wide    1 = 16-bit access, 0 = 8-bit access
//   req_addr    base byte address
//   req_wdata   write data, [7:0] is the low byte
//   rsp_valid   one-cycle completion pulse
//   rsp_rdata   read result (upper byte 0x00 on narrow reads, 0x0000 on writes)
//   mem_wen     memory write strobe (one per written byte)
//   mem_r_addr  memory read address
//   mem_w_addr  memory write address
//   mem_w_data  memory write byte
//   mem_r_data  memory read byte, combinational from mem_r_addr
//
// All outputs are registered: the next-cycle values are computed from the
// next state and loaded together with the state register.
// ---------------------------------------------------------------------------

package mem_req_ctrl_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module mem_req_ctrl
  import mem_req_ctrl_pkg::*;
#(
  parameter int unsigned BYTE_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  addr_t       req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_wen,
  output addr_t       mem_r_addr,
  output addr_t       mem_w_addr,
  output data_t       mem_w_data,
  input  data_t       mem_r_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  // Value loaded into the wait counter at every byte-phase entry; the phase
  // ends in the cycle where the counter reads zero.
  localparam logic [3:0] WAIT_LOAD = BYTE_WAIT[3:0];

  // Address of the upper byte; wraps 0xFFFF -> 0x0000.
  function automatic addr_t addr_upper(input addr_t base);
    return base + 16'd1;
  endfunction

  // Selects the write byte for the current phase.
  function automatic data_t select_byte(input logic [15:0] word, input logic upper);
    data_t b;
    if (upper) begin
      b = word[15:8];
    end else begin
      b = word[7:0];
    end
    return b;
  endfunction

  // State and latched request
  logic [1:0]  state_r;
  logic [3:0]  wait_cnt_r;
  logic        write_r;
  logic        wide_r;
  addr_t       addr_r;
  logic [15:0] wdata_r;
  logic [15:0] rdata_r;

  // Output registers
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic [15:0] rsp_rdata_r;
  logic        mem_wen_r;
  addr_t       mem_addr_r;
  data_t       mem_w_data_r;

  // Next-state values
  logic [1:0]  state_next_s;
  logic [3:0]  wait_cnt_next_s;
  logic        write_next_s;
  logic        wide_next_s;
  addr_t       addr_next_s;
  logic [15:0] wdata_next_s;
  logic [15:0] rdata_next_s;
  logic        req_ready_next_s;
  logic        rsp_valid_next_s;
  logic [15:0] rsp_rdata_next_s;
  logic        mem_wen_next_s;
  addr_t       mem_addr_next_s;
  data_t       mem_w_data_next_s;

  logic        accept_s;
  logic        phase_done_s;

  // req_ready_r is only high in IDLE, so this is the acceptance condition.
  assign accept_s     = req_valid && req_ready_r;
  assign phase_done_s = (wait_cnt_r == 4'd0);

  // Phase sequencing and wait counter reload/decrement.
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s    = ST_LO;
          wait_cnt_next_s = WAIT_LOAD;
        end else begin
          state_next_s    = ST_IDLE;
          wait_cnt_next_s = 4'd0;
        end
      end
      ST_LO: begin
        if (phase_done_s) begin
          if (wide_r) begin
            state_next_s    = ST_HI;
            wait_cnt_next_s = WAIT_LOAD;
          end else begin
            state_next_s    = ST_RSP;
            wait_cnt_next_s = 4'd0;
          end
        end else begin
          state_next_s    = ST_LO;
          wait_cnt_next_s = wait_cnt_r - 4'd1;
        end
      end
      ST_HI: begin
        if (phase_done_s) begin
          state_next_s    = ST_RSP;
          wait_cnt_next_s = 4'd0;
        end else begin
          state_next_s    = ST_HI;
          wait_cnt_next_s = wait_cnt_r - 4'd1;
        end
      end
      ST_RSP: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = 4'd0;
      end
      default: begin
        state_next_s    = ST_IDLE;
        wait_cnt_next_s = 4'd0;
      end
    endcase
  end

  // Request latching on acceptance and read-byte capture at phase ends.
  always_comb begin
    write_next_s = write_r;
    wide_next_s  = wide_r;
    addr_next_s  = addr_r;
    wdata_next_s = wdata_r;
    rdata_next_s = rdata_r;
    if (accept_s) begin
      write_next_s = req_write;
      wide_next_s  = req_wide;
      addr_next_s  = req_addr;
      wdata_next_s = req_wdata;
      // Cleared here so a narrow read reports 0x00 in the upper byte.
      rdata_next_s = 16'h0000;
    end else if (!write_r && phase_done_s && (state_r == ST_LO)) begin
      rdata_next_s[7:0] = mem_r_data;
    end else if (!write_r && phase_done_s && (state_r == ST_HI)) begin
      rdata_next_s[15:8] = mem_r_data;
    end else begin
      rdata_next_s = rdata_r;
    end
  end

  // Output values for the coming cycle, derived from the next state so the
  // outputs can be registered without a cycle of lag.
  always_comb begin
    mem_addr_next_s   = 16'h0000;
    mem_w_data_next_s = 8'h00;
    mem_wen_next_s    = 1'b0;
    case (state_next_s)
      ST_LO: begin
        mem_addr_next_s   = addr_next_s;
        mem_w_data_next_s = write_next_s ? select_byte(wdata_next_s, 1'b0) : 8'h00;
        mem_wen_next_s    = write_next_s && (wait_cnt_next_s == 4'd0);
      end
      ST_HI: begin
        mem_addr_next_s   = addr_upper(addr_next_s);
        mem_w_data_next_s = write_next_s ? select_byte(wdata_next_s, 1'b1) : 8'h00;
        mem_wen_next_s    = write_next_s && (wait_cnt_next_s == 4'd0);
      end
      default: begin
        mem_addr_next_s   = 16'h0000;
        mem_w_data_next_s = 8'h00;
        mem_wen_next_s    = 1'b0;
      end
    endcase
    req_ready_next_s = (state_next_s == ST_IDLE);
    rsp_valid_next_s = (state_next_s == ST_RSP);
    // The response word is loaded on RSP entry and then held, so it stays
    // stable through IDLE and the phases of the following transaction.
    if (state_next_s == ST_RSP) begin
      rsp_rdata_next_s = rdata_next_s;
    end else begin
      rsp_rdata_next_s = rsp_rdata_r;
    end
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 4'd0;
      write_r      <= 1'b0;
      wide_r       <= 1'b0;
      addr_r       <= 16'h0000;
      wdata_r      <= 16'h0000;
      rdata_r      <= 16'h0000;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= 16'h0000;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= 16'h0000;
      mem_w_data_r <= 8'h00;
    end else begin
      state_r      <= state_next_s;
      wait_cnt_r   <= wait_cnt_next_s;
      write_r      <= write_next_s;
      wide_r       <= wide_next_s;
      addr_r       <= addr_next_s;
      wdata_r      <= wdata_next_s;
      rdata_r      <= rdata_next_s;
      req_ready_r  <= req_ready_next_s;
      rsp_valid_r  <= rsp_valid_next_s;
      rsp_rdata_r  <= rsp_rdata_next_s;
      mem_wen_r    <= mem_wen_next_s;
      mem_addr_r   <= mem_addr_next_s;
      mem_w_data_r <= mem_w_data_next_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign mem_wen    = mem_wen_r;
  // Read and write ports always address the same byte.
  assign mem_r_addr = mem_addr_r;
  assign mem_w_addr = mem_addr_r;
  assign mem_w_data = mem_w_data_r;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
//
// Two controller instances share one clock and reset: unit 0 with
// BYTE_WAIT=0 and unit 1 with BYTE_WAIT=2. Each unit has its own byte
// memory. Expected behaviour per cycle is derived from a transaction-level
// model: phase length BYTE_WAIT+1, phase index and final-cycle position are
// computed arithmetically from the cycle offset after acceptance, and read
// data comes from a reference byte array updated per write transaction.
// ---------------------------------------------------------------------------

module tb_mem_req_ctrl;

  typedef struct packed {
    logic        ready;
    logic        rv;
    logic [15:0] rd;
    logic        wen;
    logic [15:0] ra;
    logic [15:0] wa;
    logic [7:0]  wd;
  } obs_t;

  typedef struct {
    int          u;
    bit          write;
    bit          wide;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          keep;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic        req_wide   [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [15:0] rsp_rdata  [2];
  logic        mem_wen    [2];
  logic [15:0] mem_r_addr [2];
  logic [15:0] mem_w_addr [2];
  logic [7:0]  mem_w_data [2];
  logic [7:0]  mem_r_data [2];

  bit [7:0]    mem     [2][65536];
  bit [7:0]    ref_mem [2][65536];
  logic [15:0] last_rdata [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_req_ctrl #(.BYTE_WAIT((g == 0) ? 0 : 2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_wide   (req_wide[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .mem_wen    (mem_wen[g]),
      .mem_r_addr (mem_r_addr[g]),
      .mem_w_addr (mem_w_addr[g]),
      .mem_w_data (mem_w_data[g]),
      .mem_r_data (mem_r_data[g])
    );
    assign mem_r_data[g] = mem[g][mem_r_addr[g]];
  end

  // Byte memories written by the controllers' strobes.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_wen[u]) mem[u][mem_w_addr[u]] <= mem_w_data[u];
    end
  end

  function automatic int bw(int u);
    return (u == 0) ? 0 : 2;
  endfunction

  function automatic obs_t get_obs(int u);
    obs_t o;
    o.ready = req_ready[u];
    o.rv    = rsp_valid[u];
    o.rd    = rsp_rdata[u];
    o.wen   = mem_wen[u];
    o.ra    = mem_r_addr[u];
    o.wa    = mem_w_addr[u];
    o.wd    = mem_w_data[u];
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Expected outputs c cycles after the acceptance edge (c=0: idle before).
  function automatic obs_t exp_obs(int u, bit write, bit wide, logic [15:0] addr,
                                   logic [15:0] wdata, int c,
                                   logic [15:0] rdata, logic [15:0] prev);
    obs_t o;
    int n, len, ph;
    bit fin;
    logic [15:0] a;
    o   = '0;
    n   = bw(u) + 1;
    len = wide ? 2 * n : n;
    if (c >= 1 && c <= len) begin
      ph    = (c - 1) / n;
      fin   = (((c - 1) % n) == n - 1);
      a     = (ph == 1) ? addr + 16'd1 : addr;
      o.ra  = a;
      o.wa  = a;
      o.wen = write && fin;
      o.wd  = write ? ((ph == 1) ? wdata[15:8] : wdata[7:0]) : 8'h00;
      o.rd  = prev;
    end else if (c == len + 1) begin
      o.rv = 1'b1;
      o.rd = rdata;
    end else begin
      o.ready = 1'b1;
      o.rd    = (c == 0) ? prev : rdata;
    end
    return o;
  endfunction

  function automatic logic [15:0] model_rdata(int u, bit wide, logic [15:0] addr);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    return wide ? {ref_mem[u][a1], ref_mem[u][addr]} : {8'h00, ref_mem[u][addr]};
  endfunction

  task automatic chk(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t got rdy=%b rv=%b rd=%h wen=%b ra=%h wa=%h wd=%h, want rdy=%b rv=%b rd=%h wen=%b ra=%h wa=%h wd=%h",
               name, $time, act.ready, act.rv, act.rd, act.wen, act.ra, act.wa, act.wd,
               exp.ready, exp.rv, exp.rd, exp.wen, exp.ra, exp.wa, exp.wd);
    end
  endtask

  // Called at a negedge with unit u idle; returns at a negedge with it idle.
  task automatic do_txn(string name, int u, bit write, bit wide, logic [15:0] addr,
                        logic [15:0] wdata, logic [15:0] exp_rdata, bit keep);
    int n, len;
    logic [15:0] prev, a1;
    n    = bw(u) + 1;
    len  = wide ? 2 * n : n;
    prev = last_rdata[u];
    chk($sformatf("%s/idle", name), get_obs(u),
        exp_obs(u, write, wide, addr, wdata, 0, exp_rdata, prev));
    req_valid[u] = 1'b1;
    req_write[u] = write;
    req_wide[u]  = wide;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    for (int c = 1; c <= len + 2; c++) begin
      @(negedge clk);
      chk($sformatf("%s/c%0d", name, c), get_obs(u),
          exp_obs(u, write, wide, addr, wdata, c, exp_rdata, prev));
      if (c <= len + 1) begin
        // Changes after acceptance must not affect the running transaction.
        req_valid[u] = keep ? 1'b1 : 1'($urandom_range(0, 1));
        req_write[u] = 1'($urandom_range(0, 1));
        req_wide[u]  = 1'($urandom_range(0, 1));
        req_addr[u]  = 16'($urandom);
        req_wdata[u] = 16'($urandom);
      end
    end
    req_valid[u] = 1'b0;
    if (write) begin
      a1 = addr + 16'd1;
      ref_mem[u][addr] = wdata[7:0];
      if (wide) ref_mem[u][a1] = wdata[15:8];
    end
    last_rdata[u] = exp_rdata;
  endtask

  vec_t vecs [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 1'b1, 1'b0, 16'h0001, 16'h0010, 16'h0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0010, 1'b0};
    vecs[2]  = '{0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b0};
    vecs[3]  = '{0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'hBEEF, 1'b0};
    vecs[4]  = '{0, 1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b0};
    vecs[5]  = '{0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h1234, 1'b0};
    vecs[6]  = '{0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012, 1'b0};
    vecs[7]  = '{1, 1'b1, 1'b0, 16'h0005, 16'h00AA, 16'h0000, 1'b0};
    vecs[8]  = '{1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h00AA, 1'b0};
    vecs[9]  = '{1, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'hAA00, 1'b0};
    vecs[10] = '{0, 1'b0, 1'b0, 16'h0101, 16'h0000, 16'h00BE, 1'b1};
    vecs[11] = '{0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h00EF, 1'b0};

    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u]  = 1'b0;
      req_write[u]  = 1'b0;
      req_wide[u]   = 1'b0;
      req_addr[u]   = 16'h0000;
      req_wdata[u]  = 16'h0000;
      last_rdata[u] = 16'h0000;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) chk($sformatf("reset_async%0d", u), get_obs(u), reset_obs());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) chk($sformatf("reset_release%0d", u), get_obs(u), reset_obs());

    for (int i = 0; i < 12; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].u, vecs[i].write, vecs[i].wide,
             vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].keep);
    end

    // Reset during the HI phase of a wide write on the BYTE_WAIT=2 unit.
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_wide[1]  = 1'b1;
    req_addr[1]  = 16'h0300;
    req_wdata[1] = 16'h5A3C;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid/c%0d", c), get_obs(1),
          exp_obs(1, 1'b1, 1'b1, 16'h0300, 16'h5A3C, c, 16'h0000, last_rdata[1]));
      req_valid[1] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) chk($sformatf("rst_mid_now%0d", u), get_obs(u), reset_obs());
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_held", get_obs(1), reset_obs());
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) chk($sformatf("rst_mid_after%0d", u), get_obs(u), reset_obs());
    end
    ref_mem[1][16'h0300] = 8'h3C;
    last_rdata[0] = 16'h0000;
    last_rdata[1] = 16'h0000;
    do_txn("rst_readback", 1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h003C, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int u;
      bit w, wd, kp;
      logic [15:0] a, d;
      u  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      kp = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? 16'hFFF8 : 16'h0000;
      a  = a + 16'($urandom_range(0, 7));
      d  = 16'($urandom);
      do_txn($sformatf("rand%0d", i), u, w, wd, a, d,
             w ? 16'h0000 : model_rdata(u, wd, a), kp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have parameter BYTE_WAIT, default 0, giving extra wait cycles per byte phase (0..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  requester has a transaction.
REQ-005 SHALL have port req_ready  output  1  controller can accept a transaction.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_wide  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-008 SHALL have port req_addr  input  addr_t (16)  base byte address.
REQ-009 SHALL have port req_wdata  input  16  write data; [7:0] = low byte.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  16  read result; upper byte 0x00 for narrow accesses.
REQ-012 SHALL have port mem_wen  output  1  memory write strobe.
REQ-013 SHALL have port mem_r_addr  output  addr_t  memory read address.
REQ-014 SHALL have port mem_w_addr  output  addr_t  memory write address.
REQ-015 SHALL have port mem_w_data  output  data_t (8)  memory write byte.
REQ-016 SHALL have port mem_r_data  input  data_t  memory read byte, combinational from mem_r_addr.

Function
REQ-017 SHALL implement the FSM states IDLE, LO, HI and RSP.
REQ-018 SHALL drive req_ready=1 only in IDLE; a transaction is accepted on the rising edge where req_valid && req_ready.
REQ-019 SHALL latch write, wide, addr and wdata on acceptance; later changes to the req_* inputs SHALL be ignored until the next IDLE.
REQ-020 SHALL transition IDLE->LO on acceptance; otherwise it SHALL remain in IDLE.
REQ-021 SHALL make each LO/HI byte phase last BYTE_WAIT+1 cycles, timed by a wait counter that reloads at each phase entry.
REQ-022 SHALL drive mem_r_addr = mem_w_addr = latched addr during LO, and addr+1 modulo 2^16 during HI (0xFFFF wraps to 0x0000).
REQ-023 SHALL drive both addresses to 0x0000, mem_w_data to 0x00 and mem_wen to 0 in IDLE and RSP.
REQ-024 SHALL, on a write, drive mem_w_data with wdata[7:0] in LO and wdata[15:8] in HI, and assert mem_wen only in the final cycle of each phase, giving exactly one strobe per byte.
REQ-025 SHALL, on a read, capture mem_r_data on the final-cycle edge of LO into rdata[7:0] and of HI into rdata[15:8].
REQ-026 SHALL clear the rdata capture register on acceptance, so narrow reads return 0x00 in the upper byte.
REQ-027 SHALL go LO->HI after the final LO cycle when wide, and LO->RSP when narrow; HI SHALL go to RSP after its final cycle.
REQ-028 SHALL assert rsp_valid for exactly one cycle in RSP, then go RSP->IDLE.
REQ-029 SHALL present rsp_rdata = captured rdata while rsp_valid=1 (0x0000 for writes), and hold it until the next acceptance.
REQ-030 SHALL complete a narrow access with rsp_valid in cycle A+1+(BYTE_WAIT+1), where A is the acceptance edge; a wide access SHALL take a further BYTE_WAIT+1 cycles.
REQ-031 SHALL NOT accept back-to-back transactions; the minimum spacing between acceptances is the transaction length plus 1 (the IDLE cycle).
REQ-032 SHALL deassert req_ready when req_valid is asserted during RSP; that request SHALL wait for IDLE.

Reset
REQ-033 SHALL, while rst_n=0, asynchronously force state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0x0000, mem_wen=0, addresses 0x0000, mem_w_data=0x00, wait counter 0.
REQ-034 SHALL abandon an in-flight transaction on reset mid-operation, issue no further mem_wen and produce no rsp_valid; bytes already written stay written.

Verification
REQ-035 Narrow read, BYTE_WAIT=0, mem[0x0001]=0x10, req addr=0x0001 -> mem_r_addr=0x0001 for 1 cycle; rsp_valid 2 cycles after acceptance; rsp_rdata=0x0010.
REQ-036 Wide write, BYTE_WAIT=0, addr=0x0100, wdata=0xBEEF -> mem_wen pulses with (0x0100,0xEF) then (0x0101,0xBE); then one rsp_valid.
REQ-037 Wide read at 0xFFFF with mem[0xFFFF]=0x34 and mem[0x0000]=0x12 -> HI address is 0x0000; rsp_rdata=0x1234.
REQ-038 BYTE_WAIT=2, narrow write, addr=0x0005, wdata=0x00AA -> address held 3 cycles; mem_wen only in the 3rd cycle; rsp_valid 4 cycles after acceptance.
REQ-039 rst_n pulled low during HI of a wide write -> no second mem_wen, no rsp_valid, all outputs at reset values immediately, req_ready=1 after release.
REQ-040 req_valid held high continuously with two narrow reads -> acceptances 3 cycles apart; req_ready=0 in LO and RSP; each rsp_valid exactly 1 cycle.
